// File: rtl/light_pkg.sv
// Shared types and constants for the instruction parser and the light bank array.
// Holds the command word layout, the operation encoding and the ASCII bytes
// the parser treats specially.
package light_pkg;

   localparam int OPERATION_WIDTH = 2;
   localparam int POSITION_WIDTH  = 12;
   localparam int CMD_WIDTH       = OPERATION_WIDTH + 4 * POSITION_WIDTH;

   typedef enum logic [OPERATION_WIDTH-1:0] {
      OP_OFF     = 2'd0,
      OP_ON      = 2'd1,
      OP_TOGGLE  = 2'd2,
      OP_INVALID = 2'd3
   } op_t;

   typedef logic [POSITION_WIDTH-1:0] pos_t;

   // Field order is the wire order of the command word, MSB first.
   typedef struct packed {
      op_t  op;
      pos_t start_row;
      pos_t start_col;
      pos_t end_row;
      pos_t end_col;
   } cmd_fields_t;

   typedef logic [CMD_WIDTH-1:0] cmd_t;

   localparam logic [7:0] LF    = 8'h0A;
   localparam logic [7:0] CR    = 8'h0D;
   localparam logic [7:0] SPACE = 8'h20;
   localparam logic [7:0] COMMA = 8'h2C;

   // "turn on" / "turn off" / "toggle" are told apart by their final letter.
   function automatic op_t letter_to_op(input logic [7:0] ch);
      case (ch)
         8'h6E:   return OP_ON;      // 'n'
         8'h66:   return OP_OFF;     // 'f'
         8'h65:   return OP_TOGGLE;  // 'e'
         default: return OP_INVALID;
      endcase
   endfunction

   function automatic logic is_digit(input logic [7:0] ch);
      return (ch >= 8'h30) && (ch <= 8'h39);
   endfunction

   function automatic logic is_letter(input logic [7:0] ch);
      return (ch >= 8'h61) && (ch <= 8'h7A);
   endfunction

endpackage

// File: rtl/instruction_parser_decimal_accumulator.sv
// Decimal digit accumulator: value*10 + digit per accepted digit, saturating
// at the all-ones value of WIDTH bits. The value output already includes the
// digit presented this cycle so a number can be closed on its final digit.
module decimal_accumulator #(
   parameter int WIDTH = 12
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             digit_valid,
   input  logic [3:0]       digit,
   input  logic             clear,
   output logic [WIDTH-1:0] value
);

   localparam logic [WIDTH+3:0] SAT_LIMIT = {4'b0000, {WIDTH{1'b1}}};

   logic [WIDTH-1:0] acc;

   function automatic logic [WIDTH-1:0] mul_add_sat(input logic [WIDTH-1:0] a,
                                                    input logic [3:0]       d);
      logic [WIDTH+3:0] wide;
      // a*10 = a*8 + a*2; four extra bits cover the worst case (max*10 + 9).
      wide = ({4'b0000, a} << 3) + ({4'b0000, a} << 1) + {{WIDTH{1'b0}}, d};
      return (wide > SAT_LIMIT) ? {WIDTH{1'b1}} : wide[WIDTH-1:0];
   endfunction

   assign value = digit_valid ? mul_add_sat(acc, digit) : acc;

   // Running value; clear wins so a number closed on its last digit restarts at zero.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         acc <= '0;
      end else if (clear) begin
         acc <= '0;
      end else if (digit_valid) begin
         acc <= value;
      end
   end

endmodule

// File: rtl/instruction_parser.sv
// ASCII instruction parser: turns lines such as
// "turn on 489,959 through 759,964\n" into packed command words on a
// valid/ready/last stream. One completed command is always held back so the
// final one can be flagged with cmd_last even without a trailing newline.
// Optional build macro: PARSER_NORMALIZE_EN (swap start/end per axis when
// start > end and clamp every coordinate to MAX_POSITION).
module instruction_parser #(
   parameter int CMD_DATA_WIDTH = 50,
   parameter int POSITION_WIDTH = 12,
   parameter int MAX_POSITION   = 999
) (
   input  logic                      clk,
   input  logic                      reset_n,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [7:0]                in_data,
   input  logic                      in_last,
   output logic                      cmd_valid,
   input  logic                      cmd_ready,
   output logic [CMD_DATA_WIDTH-1:0] cmd_data,
   output logic                      cmd_last,
   output logic                      parse_done
);

   import light_pkg::*;

   if ((CMD_DATA_WIDTH != CMD_WIDTH) || (MAX_POSITION > 4095) || (MAX_POSITION < 0)) begin : g_bad_params
      $error("instruction_parser: parameters inconsistent with light_pkg command layout");
   end

   typedef enum logic [1:0] {
      SCAN  = 2'd0,
      FLUSH = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t state;
   state_t state_next;

   // Line state
   op_t        line_op;
   logic       seen_digit;
   logic       in_number;
   logic [2:0] num_idx;
   pos_t       slots [4];
   pos_t       slot_now [4];

   // Hold slot and output register
   logic        hold_valid;
   cmd_t        hold_cmd;
   cmd_t        out_cmd;
   logic        armed;

   logic                      accept;
   logic                      byte_digit;
   logic                      byte_letter;
   logic                      line_end;
   logic                      close_num;
   logic                      acc_clear;
   logic                      acc_digit;
   logic [POSITION_WIDTH-1:0] acc_value;
   logic                      four_numbers;
   logic                      line_complete;
   logic                      push_out;
   logic                      flush_ready;
   logic                      flush_load;
   cmd_fields_t               raw_cmd;
   cmd_fields_t               new_cmd;

`ifdef PARSER_NORMALIZE_EN
   function automatic cmd_fields_t normalize(input cmd_fields_t c);
      cmd_fields_t r;
      pos_t        lim;
      lim = pos_t'(MAX_POSITION);
      r   = c;
      if (c.start_row > c.end_row) begin
         r.start_row = c.end_row;
         r.end_row   = c.start_row;
      end
      if (c.start_col > c.end_col) begin
         r.start_col = c.end_col;
         r.end_col   = c.start_col;
      end
      if (r.start_row > lim) r.start_row = lim;
      if (r.start_col > lim) r.start_col = lim;
      if (r.end_row   > lim) r.end_row   = lim;
      if (r.end_col   > lim) r.end_col   = lim;
      return r;
   endfunction
`endif

   assign accept      = in_valid && in_ready;
   assign byte_digit  = is_digit(in_data);
   assign byte_letter = is_letter(in_data);
   assign line_end    = (in_data == LF) || in_last;

   // A digit run closes on any non-digit, or on a line end (including a line
   // end carried by the run's own final digit).
   assign close_num = accept && ((in_number && !byte_digit) ||
                                 (line_end && (in_number || byte_digit)));
   assign acc_clear = close_num || (accept && line_end);
   assign acc_digit = accept && byte_digit;

   decimal_accumulator #(
      .WIDTH(POSITION_WIDTH)
   ) u_acc (
      .clk        (clk),
      .reset_n    (reset_n),
      .digit_valid(acc_digit),
      .digit      (in_data[3:0]),
      .clear      (acc_clear),
      .value      (acc_value)
   );

   // Slot contents as they will be once the number closing this cycle lands.
   always_comb begin
      for (int k = 0; k < 4; k++) begin
         slot_now[k] = (close_num && (num_idx == 3'(k))) ? pos_t'(acc_value) : slots[k];
      end
   end

   assign four_numbers  = (num_idx == 3'd4) || ((num_idx == 3'd3) && close_num);
   assign line_complete = accept && line_end && four_numbers && (line_op != OP_INVALID);

   assign raw_cmd.op        = line_op;
   assign raw_cmd.start_row = slot_now[0];
   assign raw_cmd.start_col = slot_now[1];
   assign raw_cmd.end_row   = slot_now[2];
   assign raw_cmd.end_col   = slot_now[3];

`ifdef PARSER_NORMALIZE_EN
   assign new_cmd = normalize(raw_cmd);
`else
   assign new_cmd = raw_cmd;
`endif

   assign push_out    = line_complete && hold_valid;
   assign flush_ready = (state == FLUSH) && (!cmd_valid || cmd_ready);
   assign flush_load  = flush_ready && hold_valid;
   assign cmd_data    = CMD_DATA_WIDTH'(out_cmd);

   // State register; armed keeps in_ready low until the first clock after reset.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= SCAN;
         armed <= 1'b0;
      end else begin
         state <= state_next;
         armed <= 1'b1;
      end
   end

   // Next-state and input handshake.
   always_comb begin
      state_next = state;
      in_ready   = 1'b0;
      unique case (state)
         SCAN: begin
            in_ready = armed && !cmd_valid;
            if (accept && in_last) state_next = FLUSH;
         end
         FLUSH: begin
            if (flush_ready) state_next = DONE;
         end
         DONE: begin
            state_next = DONE;
         end
         default: state_next = SCAN;
      endcase
   end

   // Per-line decode: op from the last letter before the first digit, numbers into slots.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         line_op    <= OP_OFF;
         seen_digit <= 1'b0;
         in_number  <= 1'b0;
         num_idx    <= '0;
         for (int k = 0; k < 4; k++) slots[k] <= '0;
      end else if (accept) begin
         if (line_end) begin
            line_op    <= OP_OFF;
            seen_digit <= 1'b0;
            in_number  <= 1'b0;
            num_idx    <= '0;
            for (int k = 0; k < 4; k++) slots[k] <= '0;
         end else begin
            if (byte_letter && !seen_digit) line_op <= letter_to_op(in_data);
            if (byte_digit) begin
               seen_digit <= 1'b1;
               in_number  <= 1'b1;
            end
            if (close_num) begin
               in_number <= 1'b0;
               // Fifth and later numbers are dropped; the index parks at 4.
               if (num_idx != 3'd4) begin
                  slots[num_idx[1:0]] <= pos_t'(acc_value);
                  num_idx             <= num_idx + 3'd1;
               end
            end
         end
      end
   end

   // Hold slot: a new command displaces the held one into the output register.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         hold_valid <= 1'b0;
         hold_cmd   <= '0;
      end else if (line_complete) begin
         hold_valid <= 1'b1;
         hold_cmd   <= new_cmd;
      end else if (flush_load) begin
         hold_valid <= 1'b0;
      end
   end

   // Output register: loaded from hold on displacement or final flush, cleared on accept.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cmd_valid <= 1'b0;
         cmd_last  <= 1'b0;
         out_cmd   <= '0;
      end else if (push_out) begin
         cmd_valid <= 1'b1;
         cmd_last  <= 1'b0;
         out_cmd   <= hold_cmd;
      end else if (flush_load) begin
         cmd_valid <= 1'b1;
         cmd_last  <= 1'b1;
         out_cmd   <= hold_cmd;
      end else if (cmd_valid && cmd_ready) begin
         cmd_valid <= 1'b0;
      end
   end

   // Sticky completion once the final command has left the output register.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         parse_done <= 1'b0;
      end else if ((state == DONE) && !cmd_valid) begin
         parse_done <= 1'b1;
      end
   end

endmodule
